// File: rtl/run_controller.sv
// Harness sequencer for one processor core. It loads a program image into
// instruction memory while holding the core in reset, releases the core and
// counts cycles until halt or watchdog, then streams a window of data memory
// out over a ready/valid port.
module run_controller #(
  parameter int unsigned WORD      = 32,
  parameter int unsigned ADDR      = 8,
  parameter int unsigned DUMP_BASE = 0,
  parameter int unsigned DUMP_LEN  = 16,
  parameter int unsigned TIMEOUT   = 100000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             load_valid_i,
  input  logic [WORD-1:0]  load_data_i,
  input  logic             load_last_i,
  output logic             load_ready_o,
  output logic [ADDR-1:0]  imem_addr_o,
  output logic [WORD-1:0]  imem_data_o,
  output logic             imem_write_o,
  output logic             core_reset_o,
  output logic             core_stall_o,
  input  logic             hlt_i,
  output logic [ADDR-1:0]  dmem_addr_o,
  input  logic [WORD-1:0]  dmem_data_i,
  output logic             dump_valid_o,
  output logic [WORD-1:0]  dump_data_o,
  output logic [ADDR-1:0]  dump_addr_o,
  input  logic             dump_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycles_o
);

  // Dump index is one bit wider than an address so DUMP_LEN = 2^ADDR fits.
  localparam int unsigned KW = ADDR + 1;
  localparam logic [ADDR-1:0]  BaseAddr   = ADDR'(DUMP_BASE);
  localparam logic [KW-1:0]    LastIdx    = KW'(DUMP_LEN - 1);
  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    StIdle, StLoad, StRun, StDumpAddr, StDumpWait, StDumpOut, StDone
  } state_e;

  state_e           r_state, w_state_d;
  logic [ADDR-1:0]  r_load_addr, w_load_addr_d;
  logic [CNT_W-1:0] r_cycles, w_cycles_d;
  logic             r_timeout, w_timeout_d;
  logic [KW-1:0]    r_k, w_k_d;
  logic [WORD-1:0]  r_dump_data, w_dump_data_d;
  logic [ADDR-1:0]  r_dump_addr, w_dump_addr_d;

  logic             w_load_accept;
  logic             w_addr_max;
  logic [ADDR-1:0]  w_dmem_addr;
  logic [CNT_W-1:0] w_cycles_inc;

  assign w_load_accept = (r_state == StLoad) && load_valid_i;
  assign w_addr_max    = &r_load_addr;
  // Truncation to ADDR bits gives the wrap at the top of data memory.
  assign w_dmem_addr   = BaseAddr + r_k[ADDR-1:0];
  assign w_cycles_inc  = (&r_cycles) ? r_cycles : r_cycles + 1'b1;

  // Next-state and datapath updates for the sequencer.
  always_comb begin
    w_state_d     = r_state;
    w_load_addr_d = r_load_addr;
    w_cycles_d    = r_cycles;
    w_timeout_d   = r_timeout;
    w_k_d         = r_k;
    w_dump_data_d = r_dump_data;
    w_dump_addr_d = r_dump_addr;
    case (r_state)
      StIdle, StDone: begin
        if (start_i) begin
          w_state_d     = StLoad;
          w_load_addr_d = '0;
          w_cycles_d    = '0;
          w_timeout_d   = 1'b0;
          w_k_d         = '0;
        end
      end
      StLoad: begin
        if (w_load_accept) begin
          // The last address is written once and never wraps back to zero.
          if (!w_addr_max) w_load_addr_d = r_load_addr + 1'b1;
          if (load_last_i || w_addr_max) w_state_d = StRun;
        end
      end
      StRun: begin
        w_cycles_d = w_cycles_inc;
        if (hlt_i) begin
          w_state_d = StDumpAddr;
        end else if (w_cycles_inc >= TimeoutCnt) begin
          w_timeout_d = 1'b1;
          w_state_d   = StDumpAddr;
        end
      end
      StDumpAddr: w_state_d = StDumpWait;
      StDumpWait: begin
        w_dump_data_d = dmem_data_i;
        w_dump_addr_d = w_dmem_addr;
        w_state_d     = StDumpOut;
      end
      StDumpOut: begin
        if (dump_ready_i) begin
          if (r_k == LastIdx) begin
            w_state_d = StDone;
          end else begin
            w_k_d     = r_k + 1'b1;
            w_state_d = StDumpAddr;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_load_addr <= '0;
      r_cycles    <= '0;
      r_timeout   <= 1'b0;
      r_k         <= '0;
      r_dump_data <= '0;
      r_dump_addr <= '0;
    end else begin
      r_state     <= w_state_d;
      r_load_addr <= w_load_addr_d;
      r_cycles    <= w_cycles_d;
      r_timeout   <= w_timeout_d;
      r_k         <= w_k_d;
      r_dump_data <= w_dump_data_d;
      r_dump_addr <= w_dump_addr_d;
    end
  end

  assign load_ready_o = (r_state == StLoad);
  assign imem_addr_o  = r_load_addr;
  assign imem_data_o  = load_data_i;
  assign imem_write_o = w_load_accept;
  assign core_reset_o = (r_state != StRun);
  assign core_stall_o = 1'b0;
  assign dmem_addr_o  = w_dmem_addr;
  assign dump_valid_o = (r_state == StDumpOut);
  assign dump_data_o  = r_dump_data;
  assign dump_addr_o  = r_dump_addr;
  assign busy_o       = (r_state != StIdle) && (r_state != StDone);
  assign done_o       = (r_state == StDone);
  assign timeout_o    = r_timeout;
  assign cycles_o     = r_cycles;

endmodule

// File: tb/tb_run_controller.sv
// Randomized self-checking bench for run_controller. Expected results come from
// the sequencing rules: image words land at consecutive addresses, run length is
// min(halt cycle, TIMEOUT), and the dump is the data window at base+k mod 2^ADDR.
module tb_run_controller;

  localparam int unsigned WORD      = 32;
  localparam int unsigned ADDR      = 8;
  localparam int unsigned DUMP_BASE = 254;
  localparam int unsigned DUMP_LEN  = 4;
  localparam int unsigned TIMEOUT   = 20;
  localparam int unsigned CNT_W     = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start_i;
  logic             load_valid_i;
  logic [WORD-1:0]  load_data_i;
  logic             load_last_i;
  logic             load_ready_o;
  logic [ADDR-1:0]  imem_addr_o;
  logic [WORD-1:0]  imem_data_o;
  logic             imem_write_o;
  logic             core_reset_o;
  logic             core_stall_o;
  logic             hlt_i;
  logic [ADDR-1:0]  dmem_addr_o;
  logic [WORD-1:0]  dmem_data_i;
  logic             dump_valid_o;
  logic [WORD-1:0]  dump_data_o;
  logic [ADDR-1:0]  dump_addr_o;
  logic             dump_ready_i;
  logic             busy_o;
  logic             done_o;
  logic             timeout_o;
  logic [CNT_W-1:0] cycles_o;

  run_controller #(
    .WORD(WORD), .ADDR(ADDR), .DUMP_BASE(DUMP_BASE), .DUMP_LEN(DUMP_LEN),
    .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i),
    .load_valid_i(load_valid_i), .load_data_i(load_data_i), .load_last_i(load_last_i),
    .load_ready_o(load_ready_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
    .imem_write_o(imem_write_o), .core_reset_o(core_reset_o), .core_stall_o(core_stall_o),
    .hlt_i(hlt_i), .dmem_addr_o(dmem_addr_o), .dmem_data_i(dmem_data_i),
    .dump_valid_o(dump_valid_o), .dump_data_o(dump_data_o), .dump_addr_o(dump_addr_o),
    .dump_ready_i(dump_ready_i), .busy_o(busy_o), .done_o(done_o),
    .timeout_o(timeout_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int unsigned cyc = 0;

  // Data memory with one-cycle read latency.
  logic [WORD-1:0] dmem [256];
  logic [WORD-1:0] dmem_rd = '0;
  always @(posedge clk) dmem_rd <= dmem[dmem_addr_o];
  assign dmem_data_i = dmem_rd;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR-1:0] addr;
    logic [WORD-1:0] data;
    int unsigned     cyc;
  } xfer_t;

  xfer_t wr_q[$];
  xfer_t dump_q[$];
  logic [WORD-1:0] ld_words [256];
  int unsigned last_cycles;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Mid-cycle monitor: record writes/handshakes and check dump hold stability.
  logic            p_hold = 1'b0;
  logic [WORD-1:0] p_data;
  logic [ADDR-1:0] p_addr;
  always @(negedge clk) begin
    if (p_hold) begin
      check_eq("hold_valid", dump_valid_o, 1'b1);
      check_eq("hold_data", dump_data_o, p_data);
      check_eq("hold_addr", dump_addr_o, p_addr);
    end
    if (!reset && imem_write_o) wr_q.push_back('{imem_addr_o, imem_data_o, cyc});
    if (!reset && dump_valid_o && dump_ready_i) dump_q.push_back('{dump_addr_o, dump_data_o, cyc});
    p_hold = !reset && dump_valid_o && !dump_ready_i;
    p_data = dump_data_o;
    p_addr = dump_addr_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_core_rst"}, core_reset_o, 1'b1);
    check_eq({tag, "_stall"}, core_stall_o, 1'b0);
    check_eq({tag, "_ld_rdy"}, load_ready_o, 1'b0);
    check_eq({tag, "_iwr"}, imem_write_o, 1'b0);
    check_eq({tag, "_dvalid"}, dump_valid_o, 1'b0);
    check_eq({tag, "_busy"}, busy_o, 1'b0);
    check_eq({tag, "_done"}, done_o, 1'b0);
    check_eq({tag, "_tmo"}, timeout_o, 1'b0);
    check_eq({tag, "_cycles"}, cycles_o, 0);
    check_eq({tag, "_iaddr"}, imem_addr_o, 0);
    check_eq({tag, "_daddr"}, dump_addr_o, 0);
  endtask

  task automatic do_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    check_eq("ld_ready", load_ready_o, 1'b1);
    check_eq("ld_addr0", imem_addr_o, 0);
    check_eq("ld_cycles0", cycles_o, 0);
    check_eq("ld_tmo0", timeout_o, 1'b0);
    check_eq("ld_done0", done_o, 1'b0);
    check_eq("ld_busy", busy_o, 1'b1);
    check_eq("ld_core_rst", core_reset_o, 1'b1);
  endtask

  // Drive n words; with gap set, valid is low every other cycle.
  task automatic do_load(input int n, input bit gap, input bit use_last);
    int step;
    step = gap ? 2 : 1;
    wr_q.delete();
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        load_valid_i = 1'b0;
        load_data_i  = $urandom;
        tick();
      end
      load_valid_i = 1'b1;
      load_data_i  = ld_words[i];
      load_last_i  = use_last && (i == n - 1);
      tick();
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    check_eq("wr_count", wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check_eq("wr_addr", wr_q[i].addr, i);
      check_eq("wr_data", wr_q[i].data, ld_words[i]);
      check_eq("wr_cycle", wr_q[i].cyc, wr_q[0].cyc + step * i);
    end
    check_eq("run_entry_core_rst", core_reset_o, 1'b0);
  endtask

  // halt = RUN cycle (1-based) on which hlt_i is raised; 0 means never.
  task automatic do_run(input int halt);
    int j;
    int exp_cyc;
    bit exp_tmo;
    exp_tmo = !(halt != 0 && halt <= int'(TIMEOUT));
    exp_cyc = exp_tmo ? int'(TIMEOUT) : halt;
    j = 0;
    while (core_reset_o == 1'b0 && j < int'(TIMEOUT) + 5) begin
      hlt_i = (j + 1 == halt);
      tick();
      j++;
    end
    hlt_i = 1'b0;
    check_eq("run_len", j, exp_cyc);
    check_eq("run_cycles", cycles_o, exp_cyc);
    check_eq("run_timeout", timeout_o, exp_tmo);
    check_eq("run_exit_core_rst", core_reset_o, 1'b1);
    last_cycles = exp_cyc;
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 5 cycles.
  task automatic do_dump(input int mode);
    int c;
    logic [ADDR-1:0] ea;
    dump_q.delete();
    c = 0;
    while (!done_o && c < 200) begin
      case (mode)
        0:       dump_ready_i = 1'b1;
        1:       dump_ready_i = 1'($urandom_range(0, 1));
        default: dump_ready_i = !(c >= 4 && c < 9);
      endcase
      tick();
      c++;
    end
    dump_ready_i = 1'b0;
    check_eq("dump_done", done_o, 1'b1);
    check_eq("dump_count", dump_q.size(), DUMP_LEN);
    for (int k = 0; k < int'(DUMP_LEN) && k < dump_q.size(); k++) begin
      ea = ADDR'(DUMP_BASE + k);
      check_eq("dump_addr", dump_q[k].addr, ea);
      check_eq("dump_data", dump_q[k].data, dmem[ea]);
      if (k > 0) check_eq("dump_spacing", dump_q[k].cyc >= dump_q[k-1].cyc + 3, 1'b1);
    end
    check_eq("done_busy", busy_o, 1'b0);
    check_eq("done_valid", dump_valid_o, 1'b0);
    check_eq("done_cycles_held", cycles_o, last_cycles);
  endtask

  task automatic full_run(input int n, input bit gap, input bit use_last, input int halt,
                          input int mode, input bit fixed);
    if (!fixed) for (int i = 0; i < n; i++) ld_words[i] = $urandom;
    for (int i = 0; i < 256; i++) dmem[i] = $urandom;
    do_start();
    do_load(n, gap, use_last);
    do_run(halt);
    do_dump(mode);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog no_finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start_i = 1'b0; load_valid_i = 1'b0; load_data_i = '0;
    load_last_i = 1'b0; hlt_i = 1'b0; dump_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = '0;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();
    check_reset_vals("idle");

    // Directed image, halt on the 10th RUN cycle.
    ld_words[0] = 32'h11; ld_words[1] = 32'h22; ld_words[2] = 32'h33; ld_words[3] = 32'h44;
    full_run(4, 1'b0, 1'b1, 10, 0, 1'b1);
    // Watchdog expiry with gapped load and a 5-cycle ready stall.
    full_run(5, 1'b1, 1'b1, 0, 2, 1'b0);
    // Halt coincides with watchdog: halt wins.
    full_run(3, 1'b0, 1'b1, int'(TIMEOUT), 1, 1'b0);
    for (int r = 0; r < 6; r++)
      full_run($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'b1,
               $urandom_range(0, 25), $urandom_range(0, 2), 1'b0);
    // Full memory image without last: leaves LOAD after the top address.
    full_run(256, 1'b0, 1'b0, 3, 0, 1'b0);

    // Reset in the middle of RUN.
    do_start();
    do_load(2, 1'b0, 1'b1);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    check_reset_vals("rst_run");
    reset = 1'b0;

    // Reset while a dump word is being offered.
    tick();
    do_start();
    do_load(2, 1'b0, 1'b1);
    do_run(1);
    dump_ready_i = 1'b0;
    for (int c = 0; c < 10 && !dump_valid_o; c++) tick();
    check_eq("reach_dump_out", dump_valid_o, 1'b1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst_dump");
    reset = 1'b0;
    tick();

    // Recovery after reset.
    full_run(6, 1'b1, 1'b1, 7, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
Synthesizable harness controller that drives one processor core end to end. It loads a program image into instruction memory and holds the core in reset while loading. It then releases the core and counts cycles until halt or watchdog timeout. Finally it streams a parametrised window of data memory out over a ready/valid port. It sits between the core top, mem_instruction (write port) and mem_data (read port), and replaces fixed-length bench loops with a generalised FPGA/bench-usable sequencer.

Parameters:
WORD, 32, instruction and data word width
ADDR, 8, instruction/data memory address width
DUMP_BASE, 0, first data-memory address dumped
DUMP_LEN, 16, number of data words dumped (1..2^ADDR)
TIMEOUT, 100000, RUN cycles before forced stop (>=1)
CNT_W, 32, cycle counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
start_i  in  1  begin LOAD from IDLE or DONE
load_valid_i  in  1  load word valid
load_data_i  in  WORD  instruction word
load_last_i  in  1  marks final load word
load_ready_o  out  1  controller accepts load word
imem_addr_o  out  ADDR  instruction memory address (valid while loading)
imem_data_o  out  WORD  instruction memory write data
imem_write_o  out  1  instruction memory write strobe
core_reset_o  out  1  core held in reset when 1
core_stall_o  out  1  core stall request
hlt_i  in  1  core halt indication
dmem_addr_o  out  ADDR  data memory read address (during DUMP)
dmem_data_i  in  WORD  data memory read data, valid one cycle after address
dump_valid_o  out  1  dump word valid
dump_data_o  out  WORD  dump word
dump_addr_o  out  ADDR  address of dump word
dump_ready_i  in  1  consumer accepts dump word
busy_o  out  1  state not IDLE/DONE
done_o  out  1  state DONE
timeout_o  out  1  run ended by watchdog, not halt
cycles_o  out  CNT_W  RUN cycle count

Behaviour:
- States: IDLE, LOAD, RUN, DUMP_ADDR, DUMP_WAIT, DUMP_OUT, DONE. Encoding is free.
- Reset (sync, any state, including mid-run or mid-dump): state=IDLE, core_reset_o=1, core_stall_o=0, load_ready_o=0, imem_write_o=0, dump_valid_o=0, busy_o=0, done_o=0, timeout_o=0, cycles_o=0, all address registers=0.
- core_reset_o=1 in every state except RUN. core_stall_o=0 always; the port is reserved for a later pause mode and is tied low here.
- IDLE/DONE: start_i -> LOAD next cycle. Entering LOAD clears cycles_o, timeout_o, the load address and done_o.
- LOAD: load_ready_o=1. A word is accepted when load_valid_i & load_ready_o. On accept: imem_write_o=1 combinationally, imem_addr_o=load address, imem_data_o=load_data_i; the load address increments after accept.
- LOAD exits to RUN after accepting a word with load_last_i=1, or after accepting the word at address 2^ADDR-1. The address does not wrap and no further writes occur. load_valid_i=0 holds LOAD indefinitely.
- RUN: cycles_o increments by 1 every RUN cycle, including the first. hlt_i=1 -> DUMP_ADDR; that cycle still counts. If cycles_o reaches TIMEOUT without halt -> timeout_o=1, DUMP_ADDR. When halt and timeout coincide, halt wins and timeout_o stays 0. cycles_o saturates and holds after RUN.
- hlt_i is ignored outside RUN. start_i is ignored outside IDLE/DONE.
- Dump index k runs 0..DUMP_LEN-1; data address = DUMP_BASE+k, mod 2^ADDR (wraps at top of memory).
- DUMP_ADDR: dmem_addr_o = DUMP_BASE+k -> DUMP_WAIT.
- DUMP_WAIT: capture dmem_data_i into the dump data register; dump_addr_o = address -> DUMP_OUT.
- DUMP_OUT: dump_valid_o=1. dump_data_o/dump_addr_o are held stable until dump_ready_i. On handshake: if k=DUMP_LEN-1 -> DONE, else k+1 and DUMP_ADDR.
- Dump throughput is at most one word per 3 cycles. dump_valid_o is never retracted without a handshake.
- DONE: done_o=1, dump_valid_o=0. cycles_o/timeout_o stay readable until the next start.

Test Plan:
- Load 4 words 0x11,0x22,0x33,0x44 (last on 4th) with continuous valid -> imem writes at addr 0..3 on 4 consecutive cycles, then RUN with core_reset_o=0 on the next cycle.
- Load with valid gaps (valid every other cycle) -> only valid cycles write; addresses stay contiguous.
- RUN, hlt_i asserted on 10th RUN cycle -> cycles_o=10, timeout_o=0, core_reset_o=1 next cycle. DUMP_LEN=4 with mem[0..3]=A,B,C,D and ready=1 -> dump A,B,C,D with addr 0..3, then done_o=1.
- TIMEOUT=20, hlt never asserted -> cycles_o=20, timeout_o=1. Variant with hlt_i on cycle 20 -> timeout_o=0.
- DUMP_BASE=254, DUMP_LEN=4, ADDR=8 -> dump addresses 254,255,0,1. Ready low for 5 cycles mid-dump -> data and addr held stable, no word lost or duplicated.
- Reset asserted mid-RUN and mid-DUMP_OUT -> IDLE next cycle with all outputs at reset values. start_i from DONE -> new LOAD at address 0 with cycles_o=0.
